// File: rtl/sdb_checker.sv
// Self-checking monitor for a dual-rail sum/difference block (SDB): recomputes the
// expected sum/carry, scores each accepted transaction and captures the first failure.
module sdb_checker #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CNT_W       = 16,
    parameter bit          STOP_ON_ERR = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] s1,
    input  logic [WIDTH-1:0] s2,
    input  logic             c_out_1,
    input  logic             c_out_2,
    input  logic             clear,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] err_count,
    output logic [4:0]       last_code,
    output logic             first_err_valid,
    output logic [4:0]       first_err_code,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b,
    output logic             first_err_cin,
    output logic             halted
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t           state_q;
    logic [1:0]       rst_sync_q;
    logic [CNT_W-1:0] pass_q;
    logic [CNT_W-1:0] err_q;
    logic [4:0]       last_code_q;
    logic             fev_q;
    logic [4:0]       fcode_q;
    logic [WIDTH-1:0] fa_q;
    logic [WIDTH-1:0] fb_q;
    logic             fcin_q;
    logic             halted_q;

    logic [WIDTH:0]   expect_d;
    logic [4:0]       code_d;
    logic             accept;

    // Reset asserts asynchronously but releases through two flops; accepts stay
    // blocked until the release has propagated, so the deasserting edge never accepts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign in_ready = (state_q == RUN) && !clear;
    assign accept   = in_valid && in_ready && rst_sync_q[1];

    always_comb begin
        expect_d  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
        code_d    = '0;
        code_d[0] = (c_out_1 != c_out_2);
        code_d[1] = (c_out_1 != expect_d[WIDTH]);
        code_d[2] = (s1 != ~s2);
        code_d[3] = (s1 != expect_d[WIDTH-1:0]);
        code_d[4] = (p != (a ^ b));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            pass_q      <= '0;
            err_q       <= '0;
            last_code_q <= '0;
            fev_q       <= 1'b0;
            fcode_q     <= '0;
            fa_q        <= '0;
            fb_q        <= '0;
            fcin_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else if (clear) begin
            state_q     <= RUN;
            pass_q      <= '0;
            err_q       <= '0;
            last_code_q <= '0;
            fev_q       <= 1'b0;
            fcode_q     <= '0;
            fa_q        <= '0;
            fb_q        <= '0;
            fcin_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else if (accept) begin
            last_code_q <= code_d;
            if (code_d == 5'd0) begin
                if (pass_q != '1) begin
                    pass_q <= pass_q + CNT_W'(1);
                end
            end else begin
                if (err_q != '1) begin
                    err_q <= err_q + CNT_W'(1);
                end
                if (!fev_q) begin
                    fev_q   <= 1'b1;
                    fcode_q <= code_d;
                    fa_q    <= a;
                    fb_q    <= b;
                    fcin_q  <= c_in;
                end
                if (STOP_ON_ERR) begin
                    state_q  <= HALT;
                    halted_q <= 1'b1;
                end
            end
        end
    end

    assign pass_count      = pass_q;
    assign err_count       = err_q;
    assign last_code       = last_code_q;
    assign first_err_valid = fev_q;
    assign first_err_code  = fcode_q;
    assign first_err_a     = fa_q;
    assign first_err_b     = fb_q;
    assign first_err_cin   = fcin_q;
    assign halted          = halted_q;

endmodule

// File: tb/tb_sdb_checker.sv
// Directed bench for sdb_checker: three instances (halt-on-error, run-on-error,
// 4-bit counters) checked against a reference model with a last_code scoreboard.
module tb_sdb_checker;

    logic       clk;
    logic       reset_n;
    logic [7:0] a, b, p, s1, s2;
    logic       c_in, co1, co2;
    logic       vld [3];
    logic       clr [3];

    logic        rdy [3];
    logic [15:0] pc [2];
    logic [15:0] ec [2];
    logic [3:0]  pc2, ec2;
    logic [4:0]  lc [3];
    logic        fv [3];
    logic [4:0]  fc [3];
    logic [7:0]  fa [3];
    logic [7:0]  fb [3];
    logic        fci [3];
    logic        hl [3];

    int errors = 0;
    int checks = 0;

    logic [4:0] sbq [$];

    int unsigned m_pass [3];
    int unsigned m_err  [3];
    logic [4:0]  m_last [3];
    logic        m_fev  [3];
    logic [4:0]  m_fcode[3];
    logic [7:0]  m_fa   [3];
    logic        m_halt [3];

    sdb_checker u0 (
        .clk(clk), .reset_n(reset_n), .in_valid(vld[0]), .in_ready(rdy[0]),
        .a(a), .b(b), .c_in(c_in), .p(p), .s1(s1), .s2(s2),
        .c_out_1(co1), .c_out_2(co2), .clear(clr[0]),
        .pass_count(pc[0]), .err_count(ec[0]), .last_code(lc[0]),
        .first_err_valid(fv[0]), .first_err_code(fc[0]), .first_err_a(fa[0]),
        .first_err_b(fb[0]), .first_err_cin(fci[0]), .halted(hl[0])
    );

    sdb_checker #(.STOP_ON_ERR(1'b0)) u1 (
        .clk(clk), .reset_n(reset_n), .in_valid(vld[1]), .in_ready(rdy[1]),
        .a(a), .b(b), .c_in(c_in), .p(p), .s1(s1), .s2(s2),
        .c_out_1(co1), .c_out_2(co2), .clear(clr[1]),
        .pass_count(pc[1]), .err_count(ec[1]), .last_code(lc[1]),
        .first_err_valid(fv[1]), .first_err_code(fc[1]), .first_err_a(fa[1]),
        .first_err_b(fb[1]), .first_err_cin(fci[1]), .halted(hl[1])
    );

    sdb_checker #(.CNT_W(4)) u2 (
        .clk(clk), .reset_n(reset_n), .in_valid(vld[2]), .in_ready(rdy[2]),
        .a(a), .b(b), .c_in(c_in), .p(p), .s1(s1), .s2(s2),
        .c_out_1(co1), .c_out_2(co2), .clear(clr[2]),
        .pass_count(pc2), .err_count(ec2), .last_code(lc[2]),
        .first_err_valid(fv[2]), .first_err_code(fc[2]), .first_err_a(fa[2]),
        .first_err_b(fb[2]), .first_err_cin(fci[2]), .halted(hl[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] ref_code(input logic [7:0] ra, input logic [7:0] rb,
                                            input logic rci, input logic [7:0] rp,
                                            input logic [7:0] rs1, input logic [7:0] rs2,
                                            input logic rc1, input logic rc2);
        int unsigned sum;
        logic [8:0]  e9;
        logic [4:0]  r;
        sum  = int'(ra) + int'(rb) + int'(rci);
        e9   = 9'(sum);
        r[0] = (rc1 !== rc2);
        r[1] = (rc1 !== e9[8]);
        r[2] = (rs1 !== (8'hFF ^ rs2));
        r[3] = (rs1 !== e9[7:0]);
        r[4] = (rp !== (ra ^ rb));
        return r;
    endfunction

    function automatic logic [31:0] get_pass(input int d);
        return (d == 2) ? 32'(pc2) : 32'(pc[d]);
    endfunction

    function automatic logic [31:0] get_err(input int d);
        return (d == 2) ? 32'(ec2) : 32'(ec[d]);
    endfunction

    task automatic model_reset(input int d);
        m_pass[d] = 0; m_err[d] = 0; m_last[d] = '0; m_fev[d] = 1'b0;
        m_fcode[d] = '0; m_fa[d] = '0; m_halt[d] = 1'b0;
    endtask

    task automatic xact(input int d, input logic [7:0] xa, input logic [7:0] xb,
                        input logic xci, input logic [7:0] xp, input logic [7:0] xs1,
                        input logic [7:0] xs2, input logic xc1, input logic xc2);
        logic [4:0]  code;
        int unsigned lim;
        logic [4:0]  exp_lc;
        @(negedge clk);
        a = xa; b = xb; c_in = xci; p = xp; s1 = xs1; s2 = xs2; co1 = xc1; co2 = xc2;
        vld[d] = 1'b1;
        lim  = (d == 2) ? 15 : 65535;
        code = ref_code(xa, xb, xci, xp, xs1, xs2, xc1, xc2);
        if (!m_halt[d] && !clr[d]) begin
            m_last[d] = code;
            if (code == 5'd0) begin
                if (m_pass[d] < lim) m_pass[d]++;
            end else begin
                if (m_err[d] < lim) m_err[d]++;
                if (!m_fev[d]) begin
                    m_fev[d] = 1'b1; m_fcode[d] = code; m_fa[d] = xa;
                end
                if (d != 1) m_halt[d] = 1'b1;
            end
        end
        sbq.push_back(m_last[d]);
        @(posedge clk);
        #1;
        vld[d] = 1'b0;
        if (sbq.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            exp_lc = sbq.pop_front();
            check("last_code", 32'(lc[d]), 32'(exp_lc));
        end
    endtask

    task automatic check_state(input int d);
        check("pass_count", get_pass(d), 32'(m_pass[d]));
        check("err_count", get_err(d), 32'(m_err[d]));
        check("first_err_valid", 32'(fv[d]), 32'(m_fev[d]));
        check("halted", 32'(hl[d]), 32'(m_halt[d]));
    endtask

    // Table of run-on-error vectors: {a,b,cin,p,s1,s2,co1,co2}, expected codes from ref_code.
    typedef struct {
        logic [7:0] ta, tb, tp, ts1, ts2;
        logic       tci, tc1, tc2;
    } vec_t;

    vec_t vecs [4];

    initial begin
        a = '0; b = '0; p = '0; s1 = '0; s2 = '0; c_in = 0; co1 = 0; co2 = 0;
        for (int i = 0; i < 3; i++) begin
            vld[i] = 1'b0; clr[i] = 1'b0; model_reset(i);
        end
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) check_state(d);
        check("reset_last_code", 32'(lc[0]), 32'h0);
        check("reset_in_ready", 32'(rdy[0]), 32'h1);

        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // Pass case on the halt-on-error instance.
        xact(0, 8'h0F, 8'hF1, 1'b0, 8'hFE, 8'h00, 8'hFF, 1'b1, 1'b1);
        check_state(0);
        check("pass_exact", get_pass(0), 32'd1);

        // Complement failure halts the checker.
        xact(0, 8'h0F, 8'hF1, 1'b0, 8'hFE, 8'h00, 8'hFE, 1'b1, 1'b1);
        check("cmpl_code", 32'(lc[0]), 32'h04);
        check_state(0);
        check("first_err_a", 32'(fa[0]), 32'h0F);
        check("first_err_b", 32'(fb[0]), 32'hF1);
        check("first_err_cin", 32'(fci[0]), 32'h0);
        check("first_err_code", 32'(fc[0]), 32'h04);
        check("halt_ready", 32'(rdy[0]), 32'h0);
        xact(0, 8'h0F, 8'hF1, 1'b0, 8'hFE, 8'h00, 8'hFF, 1'b1, 1'b1);
        check_state(0);

        // Clear wins over a simultaneous in_valid while halted.
        @(negedge clk);
        clr[0] = 1'b1; vld[0] = 1'b1;
        #1 check("clear_ready_low", 32'(rdy[0]), 32'h0);
        @(posedge clk);
        #1;
        clr[0] = 1'b0; vld[0] = 1'b0;
        model_reset(0);
        #1;
        check_state(0);
        check("clear_last_code", 32'(lc[0]), 32'h0);
        check("clear_ready", 32'(rdy[0]), 32'h1);
        check("clear_fa", 32'(fa[0]), 32'h0);

        // Multiple failures with STOP_ON_ERR=0.
        vecs[0] = '{ta:8'h80, tb:8'h80, tp:8'h00, ts1:8'h01, ts2:8'hFE, tci:1'b1, tc1:1'b1, tc2:1'b0};
        vecs[1] = '{ta:8'h80, tb:8'h80, tp:8'hFF, ts1:8'h01, ts2:8'hFE, tci:1'b1, tc1:1'b1, tc2:1'b1};
        vecs[2] = '{ta:8'h80, tb:8'h80, tp:8'h00, ts1:8'h02, ts2:8'hFD, tci:1'b1, tc1:1'b1, tc2:1'b1};
        vecs[3] = '{ta:8'h80, tb:8'h80, tp:8'h00, ts1:8'h01, ts2:8'hFE, tci:1'b1, tc1:1'b0, tc2:1'b0};
        xact(1, vecs[0].ta, vecs[0].tb, vecs[0].tci, vecs[0].tp, vecs[0].ts1, vecs[0].ts2, vecs[0].tc1, vecs[0].tc2);
        check("multi_code1", 32'(lc[1]), 32'h01);
        xact(1, vecs[1].ta, vecs[1].tb, vecs[1].tci, vecs[1].tp, vecs[1].ts1, vecs[1].ts2, vecs[1].tc1, vecs[1].tc2);
        check("multi_code2", 32'(lc[1]), 32'h10);
        check("multi_err2", get_err(1), 32'd2);
        check("multi_first_code", 32'(fc[1]), 32'h01);
        check("multi_first_a", 32'(fa[1]), 32'h80);
        check("multi_first_cin", 32'(fci[1]), 32'h1);
        check("multi_halted", 32'(hl[1]), 32'h0);
        for (int i = 2; i < 4; i++)
            xact(1, vecs[i].ta, vecs[i].tb, vecs[i].tci, vecs[i].tp, vecs[i].ts1, vecs[i].ts2, vecs[i].tc1, vecs[i].tc2);
        check_state(1);
        check("multi_first_code_kept", 32'(fc[1]), 32'h01);

        // in_ready drops combinationally on clear even while running.
        @(negedge clk);
        clr[1] = 1'b1;
        #1 check("clear_run_ready", 32'(rdy[1]), 32'h0);
        @(posedge clk);
        #1 clr[1] = 1'b0;
        model_reset(1);
        check_state(1);

        // Saturation with 4-bit counters.
        for (int i = 0; i < 17; i++) begin
            xact(2, 8'h0F, 8'hF1, 1'b0, 8'hFE, 8'h00, 8'hFF, 1'b1, 1'b1);
            if (i == 14) check("sat_at_15", get_pass(2), 32'd15);
        end
        check_state(2);
        check("sat_final", get_pass(2), 32'd15);

        // Asynchronous reset mid-stream after five passes.
        for (int i = 0; i < 5; i++)
            xact(0, 8'h12, 8'h34, 1'b1, 8'h26, 8'h47, 8'hB8, 1'b0, 1'b0);
        check("pre_reset_pass", get_pass(0), 32'd5);
        xact(1, 8'h01, 8'h01, 1'b0, 8'h00, 8'h02, 8'hFD, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) model_reset(d);
        for (int d = 0; d < 3; d++) check_state(d);
        check("rst_last_code", 32'(lc[0]), 32'h0);
        check("rst_ready", 32'(rdy[0]), 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        xact(0, 8'h0F, 8'hF1, 1'b0, 8'hFE, 8'h00, 8'hFF, 1'b1, 1'b1);
        check_state(0);

        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sdb_checker.md
SDB_CHECKER -- requirements
Module: sdb_checker

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width of the checked SDB.
REQ-002 Parameter CNT_W, default 16: width of the pass and error counters.
REQ-003 Parameter STOP_ON_ERR, default 1: when 1, the checker halts on the first failure.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  a transaction is presented on the operand and result inputs.
REQ-007 in_ready  out  1  the checker accepts a transaction this cycle.
REQ-008 a, b  in  WIDTH each  operands applied to the SDB.
REQ-009 c_in  in  1  carry-in applied to the SDB.
REQ-010 p  in  WIDTH  propagate vector supplied to the SDB.
REQ-011 s1, s2  in  WIDTH each  dual-rail sum from the SDB (true and complement).
REQ-012 c_out_1, c_out_2  in  1 each  dual-rail carry-out from the SDB.
REQ-013 clear  in  1  synchronous clear of counters, capture registers and halt.
REQ-014 pass_count, err_count  out  CNT_W each  saturating transaction counters.
REQ-015 last_code  out  5  check vector of the most recently accepted transaction.
REQ-016 first_err_valid  out  1  a failure has been captured since reset or clear.
REQ-017 first_err_code  out  5  check vector of the first failure.
REQ-018 first_err_a, first_err_b  out  WIDTH each; first_err_cin  out  1  operands of the first failure.
REQ-019 halted  out  1  FSM is in HALT.

Function
REQ-020 Accept = in_valid && in_ready at a rising edge; all result inputs are sampled on the same edge.
REQ-021 Expected value e = a + b + c_in, computed WIDTH+1 bits wide without truncation.
REQ-022 Check vector bits, each 1 = failure:
- bit0: c_out_1 != c_out_2
- bit1: c_out_1 != e[WIDTH]
- bit2: s1 != ~s2
- bit3: s1 != e[WIDTH-1:0]
- bit4: p != a^b
REQ-023 On accept, last_code takes the check vector at the same edge (latency 1 cycle).
REQ-024 Accept with vector 0 increments pass_count; nonzero vector increments err_count.
REQ-025 Counters saturate at 2^CNT_W-1 and never wrap.
REQ-026 On the first failing accept with first_err_valid=0: set first_err_valid and capture code, a, b, c_in; later failures leave the capture unchanged.
REQ-027 FSM states RUN and HALT; RUN is the reset state.
REQ-028 RUN -> HALT on a failing accept when STOP_ON_ERR=1; with STOP_ON_ERR=0 the FSM never leaves RUN.
REQ-029 HALT -> RUN only on clear.
REQ-030 in_ready = (state==RUN) && !clear, combinational.
- clear and in_valid asserted in the same cycle: clear wins; no accept.
REQ-031 clear zeroes both counters, last_code, first_err_valid and the capture fields, and moves the FSM to RUN at the next edge.
REQ-032 halted = (state==HALT), registered.

Reset
REQ-033 reset_n low asynchronously forces RUN, all counters 0, last_code 0, first_err_valid 0, captures 0, halted 0.
- in_ready is 1 while reset_n is low and clear is 0.
REQ-034 Deassertion of reset_n is synchronised to clk; no accept occurs on the deasserting edge.
REQ-035 Reset during HALT or mid-stream discards all state; no partial count survives.

Verification
REQ-036 Pass case: a=0x0F, b=0xF1, c_in=0, p=0xFE, s1=0x00, s2=0xFF, c_out_1=c_out_2=1, one accept -> pass_count=1, err_count=0, last_code=0x00.
REQ-037 Complement failure: same stimulus, s2=0xFE -> last_code=0x04, err_count=1, first_err_valid=1, first_err_a=0x0F, halted=1, in_ready=0 next cycle; further in_valid ignored.
REQ-038 Multi-failure, STOP_ON_ERR=0:
- fail #1: a=0x80, b=0x80, c_in=1, p=0x00, s1=0x01, s2=0xFE, c_out_1=1, c_out_2=0 -> code 0x01.
- fail #2: wrong p=0xFF -> code 0x10.
- required: err_count=2, first_err_code=0x01, halted=0.
REQ-039 Saturation, CNT_W=4: 17 consecutive passing accepts -> pass_count=15.
REQ-040 Clear in HALT with in_valid=1 in the same cycle -> no accept; next cycle counters 0, first_err_valid=0, halted=0, in_ready=1.
REQ-041 reset_n pulsed low mid-stream after 5 passes -> all outputs 0 immediately, without waiting for a clock edge.
